seg7_scan_ctrl: RTL and testbench

- Avalon-MM slave controller that owns a 4-digit multiplexed seven-segment display.
- Software writes hex nibbles or raw segment patterns plus per-digit blank/blink masks.
- The block time-multiplexes one shared active-low segment bus across four digit enables.
- It replaces per-digit output PIOs when the board's digits share segment lines.

---
 rtl/seg7_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Avalon-MM controlled 4-digit multiplexed seven-segment driver.
// Shared active-low segment bus, one-hot digit enables, hex/raw modes with blank/blink masks.
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_en
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [15:0]   data_q, data_d;
    logic          enable_q, enable_d;
    logic          raw_mode_q, raw_mode_d;
    logic [3:0]    blink_mask_q, blink_mask_d;
    logic [3:0]    blank_mask_q, blank_mask_d;
    logic [27:0]   raw_q, raw_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic          blink_phase_q, blink_phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    digit_q, digit_d;

    logic          wr_en;
    logic          tick;
    logic          blank_now;
    logic [3:0]    nib;
    logic [6:0]    raw_pat;
    logic          unused_wdata;

    assign unused_wdata = ^writedata[31:28];

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[15:0] = data_q;
            2'd1:    readdata[11:0] = {blank_mask_q, blink_mask_q, 2'b00, raw_mode_q, enable_q};
            2'd2:    readdata[27:0] = raw_q;
            default: readdata[2:0]  = {blink_phase_q, scan_idx_q};
        endcase
    end

    always_comb begin
        data_d        = data_q;
        enable_d      = enable_q;
        raw_mode_d    = raw_mode_q;
        blink_mask_d  = blink_mask_q;
        blank_mask_d  = blank_mask_q;
        raw_d         = raw_q;
        pre_cnt_d     = pre_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        scan_idx_d    = scan_idx_q;
        blink_phase_d = blink_phase_q;
        seg_d         = 7'h7F;
        digit_d       = '0;

        wr_en = chipselect && !write_n;
        if (wr_en) begin
            case (address)
                2'd0: data_d = writedata[15:0];
                2'd1: begin
                    enable_d     = writedata[0];
                    raw_mode_d   = writedata[1];
                    blink_mask_d = writedata[7:4];
                    blank_mask_d = writedata[11:8];
                end
                2'd2:    raw_d = writedata[27:0];
                default: ;
            endcase
        end

        // Scan timing keys off the registered enable, so a same-edge CTRL write only acts next cycle.
        tick = enable_q && (pre_cnt_q == PRE_LAST);
        if (!enable_q) begin
            pre_cnt_d     = '0;
            blink_cnt_d   = '0;
            scan_idx_d    = '0;
            blink_phase_d = 1'b0;
        end else if (tick) begin
            pre_cnt_d  = '0;
            scan_idx_d = scan_idx_q + 2'd1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
        end

        nib = data_q[{scan_idx_q, 2'b00} +: 4];
        case (scan_idx_q)
            2'd0:    raw_pat = raw_q[6:0];
            2'd1:    raw_pat = raw_q[13:7];
            2'd2:    raw_pat = raw_q[20:14];
            default: raw_pat = raw_q[27:21];
        endcase
        blank_now = blank_mask_q[scan_idx_q] || (blink_mask_q[scan_idx_q] && blink_phase_q);

        if (enable_q) begin
            digit_d = 4'b0001 << scan_idx_q;
            if (blank_now)       seg_d = 7'h7F;
            else if (raw_mode_q) seg_d = ~raw_pat;
            else                 seg_d = hex7(nib);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q        <= '0;
            enable_q      <= 1'b0;
            raw_mode_q    <= 1'b0;
            blink_mask_q  <= '0;
            blank_mask_q  <= '0;
            raw_q         <= '0;
            pre_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            scan_idx_q    <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= 7'h7F;
            digit_q       <= '0;
        end else begin
            data_q        <= data_d;
            enable_q      <= enable_d;
            raw_mode_q    <= raw_mode_d;
            blink_mask_q  <= blink_mask_d;
            blank_mask_q  <= blank_mask_d;
            raw_q         <= raw_d;
            pre_cnt_q     <= pre_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            scan_idx_q    <= scan_idx_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            digit_q       <= digit_d;
        end
    end

    assign seg_out  = seg_q;
    assign digit_en = digit_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random bus traffic,
// checked every cycle against an arithmetic model of the scan timeline.
module tb_seg7_scan_ctrl;

    localparam int SD = 4;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd3;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [6:0]  seg_out;
    logic [3:0]  digit_en;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .seg_out(seg_out), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: state of the scan is a pure function of k, the number of enabled edges.
    logic [6:0]  hex_tab [16];
    logic [15:0] m_data = '0;
    bit          m_en = 1'b0, m_raw_mode = 1'b0;
    logic [3:0]  m_blink = '0, m_blank = '0;
    logic [27:0] m_raw = '0;
    int          k = 0;
    logic [6:0]  e_seg = 7'h7F;
    logic [3:0]  e_dig = '0;

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        int t;
        t = k / SD;
        case (a)
            2'd0:    m_read = {16'h0, m_data};
            2'd1:    m_read = {20'h0, m_blank, m_blink, 2'b00, m_raw_mode, m_en};
            2'd2:    m_read = {4'h0, m_raw};
            default: m_read = 32'((t % 4) + 4 * ((t / BD) % 2));
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0; m_en <= 1'b0; m_raw_mode <= 1'b0;
            m_blink <= '0; m_blank <= '0; m_raw <= '0;
            k <= 0; e_seg <= 7'h7F; e_dig <= '0;
        end else begin
            int t, idx;
            bit ph;
            logic [27:0] rsh;
            t   = k / SD;
            idx = t % 4;
            ph  = ((t / BD) % 2) == 1;
            rsh = m_raw >> (7 * idx);
            if (m_en) begin
                e_dig <= 4'(1 << idx);
                if (m_blank[idx] || (m_blink[idx] && ph)) e_seg <= 7'h7F;
                else if (m_raw_mode)                      e_seg <= ~rsh[6:0];
                else                                      e_seg <= hex_tab[(m_data >> (4 * idx)) & 16'hF];
                k <= k + 1;
            end else begin
                e_seg <= 7'h7F;
                e_dig <= '0;
                k <= 0;
            end
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: m_data <= writedata[15:0];
                    2'd1: begin
                        m_en <= writedata[0]; m_raw_mode <= writedata[1];
                        m_blink <= writedata[7:4]; m_blank <= writedata[11:8];
                    end
                    2'd2: m_raw <= writedata[27:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("seg_model", 32'(seg_out), 32'(e_seg));
            check_eq("dig_model", 32'(digit_en), 32'(e_dig));
            check_eq("readdata_model", readdata, m_read(address));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_on();
        int n = 0;
        while (digit_en == 4'h0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_digit", 32'(digit_en), 32'h1);
    endtask

    initial begin
        logic [6:0] seq_seg [4];
        int last_t, n, seen2;
        logic prev_ph;
        seq_seg = '{7'h40, 7'h79, 7'h08, 7'h00};

        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_seg", 32'(seg_out), 32'h7F);
        check_eq("reset_dig", 32'(digit_en), 32'h0);
        check_eq("reset_status", readdata, 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_seg", 32'(seg_out), 32'h7F);
        check_eq("idle_dig", 32'(digit_en), 32'h0);

        // Hex scan sequence from a cold start
        wr(2'd0, 32'h8A10);
        wr(2'd1, 32'h1);
        wait_on();
        check_eq("scan_seg0", 32'(seg_out), 32'h40);
        for (int s = 1; s <= 4; s++) begin
            repeat (SD) @(negedge clk);
            check_eq("scan_dig", 32'(digit_en), 32'(1 << (s % 4)));
            check_eq("scan_seg", 32'(seg_out), 32'(seq_seg[s % 4]));
        end

        // Raw mode, only digit 2 fully lit
        wr(2'd2, 32'h001F_C000);
        wr(2'd1, 32'h3);
        @(posedge clk);
        repeat (16) begin
            @(negedge clk);
            check_eq("raw_seg", 32'(seg_out), (digit_en == 4'h4) ? 32'h00 : 32'h7F);
        end

        // Blink on digit 0; blink_phase period observed on STATUS
        wr(2'd0, 32'h5);
        wr(2'd1, 32'h11);
        @(posedge clk);
        address = 2'd3;
        last_t = -1;
        prev_ph = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digit_en == 4'h1)
                check_eq("blink_d0", 32'(seg_out == 7'h12 || seg_out == 7'h7F), 32'h1);
            else
                check_eq("blink_other", 32'(seg_out), 32'h40);
            if (i > 0 && readdata[2] != prev_ph) begin
                if (last_t >= 0) check_eq("phase_period", 32'(i - last_t), 32'd8);
                last_t = i;
            end
            prev_ph = readdata[2];
        end

        // Blank digit 1
        wr(2'd1, 32'h201);
        @(posedge clk);
        seen2 = 0;
        repeat (16) begin
            @(negedge clk);
            if (digit_en == 4'h2) begin
                seen2++;
                check_eq("blank_d1", 32'(seg_out), 32'h7F);
            end
            if (digit_en == 4'h1) check_eq("blank_d0", 32'(seg_out), 32'h12);
        end
        check_eq("blank_slot_seen", 32'(seen2 > 0), 32'h1);

        // Disable mid-scan, then restart
        n = 0;
        while (digit_en != 4'h4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_d2", 32'(digit_en), 32'h4);
        wr(2'd1, 32'h0);
        address = 2'd3;
        @(posedge clk);
        @(negedge clk);
        check_eq("off_seg", 32'(seg_out), 32'h7F);
        check_eq("off_dig", 32'(digit_en), 32'h0);
        check_eq("off_status", readdata, 32'h0);
        wr(2'd1, 32'h1);
        wait_on();
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd1; #1;
        check_eq("ro_ctrl", readdata, 32'h1);
        address = 2'd0; #1;
        check_eq("ro_data", readdata, 32'h5);
        address = 2'd2; #1;
        check_eq("ro_raw", readdata, 32'h001F_C000);

        // Random bus traffic
        repeat (500) begin
            int r;
            @(negedge clk); #1;
            r = int'($urandom % 10);
            address = 2'($urandom);
            writedata = $urandom;
            if (address == 2'd1) writedata[0] = ($urandom % 6) != 0;
            if (r < 2) begin
                chipselect = 1'b1; write_n = 1'b0;
            end else if (r < 4) begin
                chipselect = 1'b0; write_n = 1'b0;
            end else begin
                chipselect = r[0]; write_n = 1'b1;
            end
        end
        @(negedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        wr(2'd1, 32'h1);
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-run
        address = 2'd3;
        #2 reset = 1'b1;
        #1;
        check_eq("midreset_seg", 32'(seg_out), 32'h7F);
        check_eq("midreset_dig", 32'(digit_en), 32'h0);
        check_eq("midreset_status", readdata, 32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("postreset_seg", 32'(seg_out), 32'h7F);
        check_eq("postreset_dig", 32'(digit_en), 32'h0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
